// File: rtl/bsg_rocket_fsb_out_arbiter.sv
// rtl/bsg_rocket_fsb_out_arbiter.sv - round-robin FSB output arbiter, optional burst lock via BSG_ROCKET_FSB_ARB_BURST_EN
module bsg_rocket_fsb_out_arbiter #(
    parameter int num_clients_p = 2,
    parameter int width_p       = 80,
    parameter int burst_p       = 4,
    localparam int id_w_lp      = $clog2(num_clients_p)
) (
    input  logic                               clk_i,
    input  logic                               reset_i,
    input  logic                               en_i,
    input  logic [num_clients_p-1:0]           v_i,
    input  logic [num_clients_p*width_p-1:0]   data_i,
    output logic [num_clients_p-1:0]           yumi_o,
    output logic                               fsb_node_v_o,
    output logic [width_p-1:0]                 fsb_node_data_o,
    input  logic                               fsb_node_yumi_i,
    output logic [id_w_lp-1:0]                 grant_id_o
);

    if (num_clients_p < 2 || burst_p < 1) begin : g_bad_params
        $error("bsg_rocket_fsb_out_arbiter: num_clients_p must be >= 2 and burst_p >= 1");
    end

    logic               obuf_v;
    logic [width_p-1:0] obuf_data;
    logic [id_w_lp-1:0] obuf_id;
    logic [id_w_lp-1:0] last_grant;

    logic               can_accept;
    logic               grant_ok;
    logic               rr_v;
    logic [id_w_lp-1:0] rr_id;
    logic [id_w_lp-1:0] cand;
    logic               lock_hold;
    logic               grant_v;
    logic [id_w_lp-1:0] grant_id;

    assign can_accept = ~obuf_v | fsb_node_yumi_i;
    assign grant_ok   = ~reset_i & en_i & can_accept;

    // First valid requester searching upward from last_grant+1, wrapping at num_clients_p.
    always_comb begin
        rr_v  = 1'b0;
        rr_id = '0;
        cand  = '0;
        for (int i = 0; i < num_clients_p; i++) begin
            cand = id_w_lp'((int'(last_grant) + 1 + i) % num_clients_p);
            if (!rr_v && v_i[cand]) begin
                rr_v  = 1'b1;
                rr_id = cand;
            end
        end
    end

`ifdef BSG_ROCKET_FSB_ARB_BURST_EN
    localparam int cnt_w_lp = $clog2(burst_p + 1);

    logic                lock_v;
    logic [cnt_w_lp-1:0] burst_cnt;

    // last_grant doubles as the lock owner since it always tracks the locked requester.
    assign lock_hold = lock_v & v_i[last_grant] & (burst_cnt < cnt_w_lp'(burst_p));

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            lock_v    <= 1'b0;
            burst_cnt <= '0;
        end else if (grant_ok) begin
            if (lock_hold) begin
                burst_cnt <= burst_cnt + cnt_w_lp'(1);
            end else if (rr_v) begin
                lock_v    <= 1'b1;
                burst_cnt <= cnt_w_lp'(1);
            end else begin
                lock_v    <= 1'b0;
                burst_cnt <= '0;
            end
        end
    end
`else
    assign lock_hold = 1'b0;
`endif

    always_comb begin
        grant_v  = 1'b0;
        grant_id = rr_id;
        if (grant_ok) begin
            if (lock_hold) begin
                grant_v  = 1'b1;
                grant_id = last_grant;
            end else if (rr_v) begin
                grant_v  = 1'b1;
                grant_id = rr_id;
            end
        end
    end

    assign yumi_o = grant_v ? ({{(num_clients_p-1){1'b0}}, 1'b1} << grant_id) : '0;

    // A grant overwrites obuf in the same cycle it drains, so back-to-back beats have no bubble.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            obuf_v     <= 1'b0;
            obuf_data  <= '0;
            obuf_id    <= '0;
            last_grant <= id_w_lp'(num_clients_p - 1);
        end else if (grant_v) begin
            obuf_v     <= 1'b1;
            obuf_data  <= data_i[int'(grant_id)*width_p +: width_p];
            obuf_id    <= grant_id;
            last_grant <= grant_id;
        end else if (fsb_node_yumi_i) begin
            obuf_v <= 1'b0;
        end
    end

    assign fsb_node_v_o    = obuf_v;
    assign fsb_node_data_o = obuf_data;
    assign grant_id_o      = obuf_id;

endmodule

// File: tb/tb_bsg_rocket_fsb_out_arbiter.sv
// tb/tb_bsg_rocket_fsb_out_arbiter.sv - randomized model-checked bench for bsg_rocket_fsb_out_arbiter
module tb_bsg_rocket_fsb_out_arbiter;

    localparam int N = 3;
    localparam int W = 16;
    localparam int B = 4;
    localparam int IW = $clog2(N);
`ifdef BSG_ROCKET_FSB_ARB_BURST_EN
    localparam bit BURST = 1'b1;
`else
    localparam bit BURST = 1'b0;
`endif

    logic           clk = 1'b0;
    logic           reset_i = 1'b1;
    logic           en_i = 1'b0;
    logic [N-1:0]   v_i = '0;
    logic [N*W-1:0] data_i = '0;
    logic [N-1:0]   yumi_o;
    logic           fsb_node_v_o;
    logic [W-1:0]   fsb_node_data_o;
    logic           fsb_node_yumi_i = 1'b0;
    logic [IW-1:0]  grant_id_o;

    int errors = 0;
    int checks = 0;

    // Reference state: the held beat, who was served last, and the burst lock.
    bit           m_ov;
    logic [W-1:0] m_data;
    int           m_id;
    int           m_last;
    bit           m_lock;
    int           m_cnt;

    always #5 clk = ~clk;

    bsg_rocket_fsb_out_arbiter #(.num_clients_p(N), .width_p(W), .burst_p(B)) dut (
        .clk_i(clk), .reset_i(reset_i), .en_i(en_i), .v_i(v_i), .data_i(data_i),
        .yumi_o(yumi_o), .fsb_node_v_o(fsb_node_v_o), .fsb_node_data_o(fsb_node_data_o),
        .fsb_node_yumi_i(fsb_node_yumi_i), .grant_id_o(grant_id_o)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_ov = 0; m_data = '0; m_id = 0; m_last = N - 1; m_lock = 0; m_cnt = 0;
    endtask

    // One clock: drive at negedge, check just after, then advance the model at posedge.
    task automatic cycle(input bit rst, input bit en, input bit yum, input logic [N-1:0] v);
        int  k;
        bit  held;
        bit  can;
        logic [N-1:0] exp_yumi;
        reset_i = rst; en_i = en; fsb_node_yumi_i = yum; v_i = v;
        data_i = (N*W)'({$urandom(), $urandom()});
        #1;
        k = -1;
        can = !m_ov || yum;
        held = BURST && m_lock && v[m_last] && (m_cnt < B);
        if (!rst && en && can) begin
            if (held) k = m_last;
            else begin
                for (int i = 1; i <= N; i++) begin
                    int c = (m_last + i) % N;
                    if (k < 0 && v[c]) k = c;
                end
            end
        end
        exp_yumi = '0;
        if (k >= 0) exp_yumi[k] = 1'b1;
        check("yumi_o", 32'(yumi_o), 32'(exp_yumi));
        check("fsb_node_v_o", 32'(fsb_node_v_o), 32'(m_ov));
        check("grant_id_o", 32'(grant_id_o), 32'(m_id));
        if (m_ov) check("fsb_node_data_o", 32'(fsb_node_data_o), 32'(m_data));
        @(posedge clk);
        if (rst) model_reset();
        else begin
            if (yum) m_ov = 0;
            if (k >= 0) begin
                m_ov = 1; m_data = data_i[k*W +: W]; m_id = k; m_last = k;
            end
            if (BURST && en && can) begin
                if (held) m_cnt++;
                else if (k >= 0) begin m_lock = 1; m_cnt = 1; end
                else begin m_lock = 0; m_cnt = 0; end
            end
        end
        @(negedge clk);
    endtask

    initial begin
        model_reset();
        @(negedge clk);
        repeat (2) cycle(1, 0, 0, '0);
        check("reset_fsb_node_v_o", 32'(fsb_node_v_o), 32'd0);
        // Two requesters, drain every cycle: alternating grants.
        repeat (6) cycle(0, 1, 1, 3'b011);
        // Full and stalled for 5 cycles, then release.
        repeat (5) cycle(0, 1, 0, 3'b111);
        repeat (2) cycle(0, 1, 1, 3'b111);
        // Enable off: beat drains and nothing new is taken.
        cycle(0, 1, 0, 3'b111);
        repeat (3) cycle(0, 0, 1, 3'b111);
        check("drained_v", 32'(fsb_node_v_o), 32'd0);
        // Fresh start, all valid: per-beat round robin or 4-beat bursts.
        cycle(1, 0, 0, '0);
        repeat (13) cycle(0, 1, 1, 3'b111);
        // Requester 0 leaves mid-burst while requester 2 waits.
        cycle(1, 0, 0, '0);
        repeat (2) cycle(0, 1, 1, 3'b101);
        repeat (3) cycle(0, 1, 1, 3'b100);
        // Reset with a held beat and active lock.
        repeat (2) cycle(0, 1, 0, 3'b111);
        cycle(1, 1, 0, 3'b111);
        check("post_reset_v", 32'(fsb_node_v_o), 32'd0);
        repeat (3) cycle(0, 1, 1, 3'b111);
        // Random traffic.
        for (int n = 0; n < 3000; n++) begin
            cycle(($urandom_range(0, 199) == 0), ($urandom_range(0, 7) != 0),
                  $urandom_range(0, 1) == 1, N'($urandom()));
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
